conv_channel_aligner: RTL and testbench

// Collects output columns from NUM_CH parallel convolution engines that share one input stream
//   but may finish each column on different cycles.

---
 rtl/conv_channel_aligner.sv | 166 ++++++++++++++++
 tb/tb_conv_channel_aligner.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_channel_aligner.sv
// conv_channel_aligner
//   Gathers one output column from each of NUM_CH parallel conv engines, which
//   share an input stream but may finish a column on different cycles, and
//   presents a channel-aligned bundle to the pooling / write-back stage over a
//   valid/ready handshake.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   start      begin a frame (only honoured in IDLE); latches ch_mask
//   ch_mask    enabled-channel mask
//   ch_col     per-channel column data, NUM_CH x COL_SIZE x DATA_WIDTH
//   ch_valid   per-channel column strobe
//   ch_stall   per-channel backpressure: slot full and not draining this cycle
//   col_out    aligned bundle; disabled lanes read zero
//   col_valid  col_out holds a column
//   col_ready  downstream accepts col_out
//   col_idx    index of the column on col_out (0..OUT_COLS-1)
//   busy       frame in progress (COLLECT)
//   done       one-cycle pulse after the last column of a frame
//   overrun    sticky: a column arrived at a full, non-draining slot and was lost
module conv_channel_aligner #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_CH     = 4,
  parameter int COL_SIZE   = 24,
  parameter int OUT_COLS   = 24,
  localparam int CNT_W     = $clog2(OUT_COLS + 1)
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         start,
  input  logic [NUM_CH-1:0]                            ch_mask,
  input  logic [NUM_CH-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] ch_col,
  input  logic [NUM_CH-1:0]                            ch_valid,
  output logic [NUM_CH-1:0]                            ch_stall,
  output logic [NUM_CH-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] col_out,
  output logic                                         col_valid,
  input  logic                                         col_ready,
  output logic [CNT_W-1:0]                             col_idx,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         overrun
);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DONE} state_t;
  typedef logic [NUM_CH-1:0][COL_SIZE-1:0][DATA_WIDTH-1:0] bundle_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(OUT_COLS - 1);

  state_t            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [NUM_CH-1:0] full_q, full_d;
  logic              vld_q, vld_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic              ovr_q, ovr_d;
  bundle_t           col_q, col_d;
  bundle_t           slot_q;

  logic              collecting;
  logic              hs;
  logic              last_hs;
  logic              all_full;
  logic              xfer;
  logic [NUM_CH-1:0] cap;

  always_comb begin
    collecting = (state_q == S_COLLECT);
    hs         = collecting && vld_q && col_ready;
    last_hs    = hs && (idx_q == LAST_IDX);
    // An all-disabled mask never transfers; that frame ends with no columns.
    all_full   = (mask_q != '0) && ((full_q & mask_q) == mask_q);
    // No transfer on the final handshake: the frame is over, leftovers are dropped.
    xfer       = collecting && all_full && (!vld_q || col_ready) && !last_hs;
    // A full slot may still capture when it is being drained in the same cycle.
    cap        = {NUM_CH{collecting}} & ch_valid & mask_q & (~full_q | {NUM_CH{xfer}});
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    full_d  = full_q;
    vld_d   = vld_q;
    idx_d   = idx_q;
    ovr_d   = ovr_q;
    col_d   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_COLLECT;
          mask_d  = ch_mask;
          full_d  = '0;
          vld_d   = 1'b0;
          idx_d   = '0;
          ovr_d   = 1'b0;
        end
      end
      S_COLLECT: begin
        full_d = (full_q & ~({NUM_CH{xfer}} & mask_q)) | cap;
        if (((ch_valid & mask_q & full_q) != '0) && !xfer) begin
          ovr_d = 1'b1;
        end
        if (xfer) begin
          vld_d = 1'b1;
          for (int i = 0; i < NUM_CH; i++) begin
            col_d[i] = mask_q[i] ? slot_q[i] : '0;
          end
        end else if (hs) begin
          vld_d = 1'b0;
        end
        if (hs) begin
          idx_d = last_hs ? '0 : idx_q + 1'b1;
        end
        if (last_hs || (mask_q == '0)) begin
          state_d = S_DONE;
          full_d  = '0;
          vld_d   = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        full_d  = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mask_q  <= '0;
      full_q  <= '0;
      vld_q   <= 1'b0;
      idx_q   <= '0;
      ovr_q   <= 1'b0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      full_q  <= full_d;
      vld_q   <= vld_d;
      idx_q   <= idx_d;
      ovr_q   <= ovr_d;
      col_q   <= col_d;
    end
  end

  // Slot storage carries no reset: its contents only matter while full_q is set.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (cap[i]) begin
        slot_q[i] <= ch_col[i];
      end
    end
  end

  assign ch_stall  = full_q & ~{NUM_CH{xfer}};
  assign col_out   = col_q;
  assign col_valid = vld_q;
  assign col_idx   = idx_q;
  assign busy      = collecting;
  assign done      = (state_q == S_DONE);
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_conv_channel_aligner.sv
module tb_conv_channel_aligner;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int CS = 24;
  localparam int OC = 24;
  localparam int CW = $clog2(OC + 1);

  typedef logic [CS-1:0][DW-1:0]         lane_t;
  typedef logic [NC-1:0][CS-1:0][DW-1:0] bundle_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [NC-1:0] ch_mask;
  bundle_t       ch_col;
  logic [NC-1:0] ch_valid;
  logic [NC-1:0] ch_stall;
  bundle_t       col_out;
  logic          col_valid;
  logic          col_ready;
  logic [CW-1:0] col_idx;
  logic          busy;
  logic          done;
  logic          overrun;

  int n_checks = 0;
  int n_fail   = 0;

  conv_channel_aligner #(
    .DATA_WIDTH(DW), .NUM_CH(NC), .COL_SIZE(CS), .OUT_COLS(OC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .ch_mask(ch_mask), .ch_col(ch_col),
    .ch_valid(ch_valid), .ch_stall(ch_stall), .col_out(col_out),
    .col_valid(col_valid), .col_ready(col_ready), .col_idx(col_idx),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(input string tag, input lane_t obs, input lane_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bundle(input string tag, input bundle_t exp);
    for (int i = 0; i < NC; i++) begin
      chk_lane($sformatf("%s lane%0d", tag, i), col_out[i], exp[i]);
    end
  endtask

  function automatic lane_t ramp_lane(input int ch, input int c);
    lane_t l;
    for (int j = 0; j < CS; j++) l[j] = DW'(32'h1000 * ch + 32'h40 * c + j);
    return l;
  endfunction

  function automatic lane_t const_lane(input int v);
    lane_t l;
    for (int j = 0; j < CS; j++) l[j] = DW'(v);
    return l;
  endfunction

  function automatic bundle_t ramp_bundle(input int c);
    bundle_t b;
    for (int i = 0; i < NC; i++) b[i] = ramp_lane(i, c);
    return b;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ramp(input int c, input logic [NC-1:0] v);
    ch_col   = ramp_bundle(c);
    ch_valid = v;
  endtask

  task automatic do_reset;
    rst = 1'b1; start = 1'b0; ch_valid = '0; col_ready = 1'b1; ch_mask = '0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic begin_frame(input logic [NC-1:0] m);
    ch_mask = m; start = 1'b1;
    tick;
    start = 1'b0;
  endtask

  initial begin
    int      beats;
    int      dones;
    bundle_t exp_b;

    // Reset state
    rst = 1'b1; start = 1'b0; ch_mask = '0; ch_col = '0; ch_valid = '0; col_ready = 1'b1;
    tick;
    chk("rst col_valid", 32'(col_valid), 0);
    chk("rst col_idx", 32'(col_idx), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst done", 32'(done), 0);
    chk("rst overrun", 32'(overrun), 0);
    chk("rst ch_stall", 32'(ch_stall), 0);
    chk_bundle("rst col_out", '0);
    rst = 1'b0;
    tick;

    // T1 aligned full frame
    begin_frame(4'hF);
    chk("t1 busy", 32'(busy), 1);
    beats = 0;
    dones = 0;
    for (int c = 0; c < OC; c++) begin
      drive_ramp(c, 4'hF);
      tick;
      if (col_valid) begin
        chk($sformatf("t1 idx b%0d", beats), 32'(col_idx), 32'(beats));
        chk_bundle($sformatf("t1 data b%0d", beats), ramp_bundle(beats));
        beats++;
      end
    end
    ch_valid = '0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (col_valid) begin
        chk($sformatf("t1 idx b%0d", beats), 32'(col_idx), 32'(beats));
        chk_bundle($sformatf("t1 data b%0d", beats), ramp_bundle(beats));
        beats++;
      end
      if (done) dones++;
    end
    chk("t1 beats", 32'(beats), 24);
    chk("t1 done pulses", 32'(dones), 1);
    chk("t1 overrun", 32'(overrun), 0);
    chk("t1 busy end", 32'(busy), 0);
    chk("t1 idx end", 32'(col_idx), 0);

    // T2 skewed arrival
    do_reset;
    begin_frame(4'hF);
    for (int i = 0; i < NC; i++) ch_col[i] = const_lane(32'h1000 + i);
    for (int t = 0; t <= 10; t++) begin
      ch_valid = {t == 9, t == 5, t == 3, t == 0};
      tick;
      ch_valid = '0;
      chk($sformatf("t2 col_valid t%0d", t), 32'(col_valid), 32'(t >= 10));
      if (t == 0) chk("t2 stall t0", 32'(ch_stall), 32'h1);
      if (t == 5) chk("t2 stall t5", 32'(ch_stall), 32'h7);
      if (t == 9) chk("t2 stall t9", 32'(ch_stall), 32'h0);
    end
    for (int i = 0; i < NC; i++) exp_b[i] = const_lane(32'h1000 + i);
    chk_bundle("t2 data", exp_b);
    chk("t2 idx", 32'(col_idx), 0);

    // T3 backpressure, overrun, start ignored mid-frame
    do_reset;
    col_ready = 1'b0;
    begin_frame(4'hF);
    drive_ramp(0, 4'hF);
    tick;
    drive_ramp(1, 4'hF);
    tick;
    ch_valid = '0;
    chk("t3 col_valid", 32'(col_valid), 1);
    chk("t3 stall full", 32'(ch_stall), 32'hF);
    chk("t3 overrun pre", 32'(overrun), 0);
    for (int k = 0; k < 10; k++) begin
      if (k == 4) begin
        drive_ramp(9, 4'hF);
        start = 1'b1; ch_mask = '0;
      end else begin
        ch_valid = '0; start = 1'b0;
      end
      tick;
      chk_bundle($sformatf("t3 hold k%0d", k), ramp_bundle(0));
      chk($sformatf("t3 hold idx k%0d", k), 32'(col_idx), 0);
      chk($sformatf("t3 hold stall k%0d", k), 32'(ch_stall), 32'hF);
    end
    start = 1'b0; ch_valid = '0;
    chk("t3 overrun set", 32'(overrun), 1);
    chk("t3 busy", 32'(busy), 1);
    col_ready = 1'b1;
    #1;
    chk("t3 stall draining", 32'(ch_stall), 0);
    tick;
    chk("t3 col_valid next", 32'(col_valid), 1);
    chk("t3 idx next", 32'(col_idx), 1);
    chk_bundle("t3 kept col1", ramp_bundle(1));
    tick;
    chk("t3 col_valid drained", 32'(col_valid), 0);
    chk("t3 idx drained", 32'(col_idx), 2);
    chk("t3 overrun sticky", 32'(overrun), 1);

    // T4 channel mask 0101
    do_reset;
    begin_frame(4'b0101);
    for (int i = 0; i < NC; i++) ch_col[i] = const_lane(32'h2000 + i);
    ch_valid = 4'hF;
    tick;
    ch_valid = '0;
    chk("t4 stall", 32'(ch_stall), 0);
    tick;
    chk("t4 col_valid", 32'(col_valid), 1);
    exp_b[0] = const_lane(32'h2000);
    exp_b[1] = '0;
    exp_b[2] = const_lane(32'h2002);
    exp_b[3] = '0;
    chk_bundle("t4 data", exp_b);
    ch_valid = 4'b1010;
    tick;
    ch_valid = '0;
    tick;
    chk("t4 masked ignored valid", 32'(col_valid), 0);
    chk("t4 idx", 32'(col_idx), 1);
    chk("t4 stall masked", 32'(ch_stall), 0);
    chk("t4 overrun", 32'(overrun), 0);

    // T4b empty mask: done two cycles after start
    do_reset;
    begin_frame('0);
    chk("t4b busy", 32'(busy), 1);
    chk("t4b done early", 32'(done), 0);
    tick;
    chk("t4b done", 32'(done), 1);
    chk("t4b col_valid", 32'(col_valid), 0);
    chk("t4b busy in done", 32'(busy), 0);
    tick;
    chk("t4b done clears", 32'(done), 0);

    // T5 capture during transfer, back-to-back output
    do_reset;
    begin_frame(4'hF);
    drive_ramp(0, 4'hF);
    tick;
    drive_ramp(1, 4'hF);
    tick;
    ch_valid = '0;
    chk("t5 first valid", 32'(col_valid), 1);
    chk_bundle("t5 first data", ramp_bundle(0));
    chk("t5 overrun", 32'(overrun), 0);
    tick;
    chk("t5 b2b valid", 32'(col_valid), 1);
    chk("t5 b2b idx", 32'(col_idx), 1);
    chk_bundle("t5 b2b data", ramp_bundle(1));
    chk("t5 overrun after", 32'(overrun), 0);

    // T6 reset mid-frame
    do_reset;
    begin_frame(4'hF);
    for (int c = 0; c <= 8; c++) begin
      drive_ramp(c, 4'hF);
      tick;
    end
    chk("t6 idx at 7", 32'(col_idx), 7);
    col_ready = 1'b0;
    tick;
    chk("t6 overrun before rst", 32'(overrun), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("t6 col_valid", 32'(col_valid), 0);
    chk("t6 idx", 32'(col_idx), 0);
    chk("t6 busy", 32'(busy), 0);
    chk("t6 done", 32'(done), 0);
    chk("t6 overrun", 32'(overrun), 0);
    chk("t6 stall", 32'(ch_stall), 0);
    chk_bundle("t6 col_out", '0);
    ch_valid = '0; col_ready = 1'b1;
    tick;
    rst = 1'b0;
    begin_frame(4'hF);
    chk("t6 restart busy", 32'(busy), 1);
    chk("t6 restart idx", 32'(col_idx), 0);
    chk("t6 restart overrun", 32'(overrun), 0);
    drive_ramp(3, 4'hF);
    tick;
    ch_valid = '0;
    tick;
    chk("t6 restart valid", 32'(col_valid), 1);
    chk("t6 restart idx0", 32'(col_idx), 0);
    chk_bundle("t6 restart data", ramp_bundle(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
